// File: rtl/apb_bridge_arbiter.sv
// Two-requester round-robin arbiter that drives one APB SETUP/ACCESS transfer at a time
// into a UART or timer window. Results go back as a done/err pulse to the granted requester.
module apb_bridge_arbiter #(
  parameter int unsigned         ADDR_W     = 12,
  parameter int unsigned         DATA_W     = 32,
  parameter int unsigned         TIMEOUT    = 16,
  parameter logic [ADDR_W-1:0]   UART_BASE  = ADDR_W'(12'h800),
  parameter logic [ADDR_W-1:0]   TIMER_BASE = ADDR_W'(12'hA00)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_m0_req,
  input  logic              i_m0_write,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic              i_m1_req,
  input  logic              i_m1_write,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m0_done,
  output logic              o_m0_err,
  output logic              o_m1_done,
  output logic              o_m1_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic [8:0]        o_paddr,
  output logic              o_pwrite,
  output logic [DATA_W-1:0] o_pwdata,
  output logic              o_psel_uart,
  output logic              o_psel_timer,
  output logic              o_penable,
  input  logic [DATA_W-1:0] i_prdata_uart,
  input  logic [DATA_W-1:0] i_prdata_timer,
  input  logic              i_pready_uart,
  input  logic              i_pready_timer
);

  localparam int unsigned       CntW    = $clog2(TIMEOUT + 1);
  // Counter holds ACCESS cycles already spent, so the TIMEOUT-th cycle sees TIMEOUT-1.
  localparam logic [CntW-1:0]   CntLast = CntW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] WinLast = ADDR_W'(511);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_last_grant, w_last_grant_nxt;
  logic              r_gnt, w_gnt_nxt;
  logic              r_pwrite, w_pwrite_nxt;
  logic [8:0]        r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0] r_pwdata, w_pwdata_nxt;
  logic              r_psel_uart, w_psel_uart_nxt;
  logic              r_psel_timer, w_psel_timer_nxt;
  logic              r_penable, w_penable_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              r_m0_done, r_m0_err, r_m1_done, r_m1_err, r_busy;
  logic              w_fin, w_fin_err;

  // Request selection: m1 wins alone, or on contention when m0 was served last.
  logic              w_pick_m1;
  logic              w_req_write;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_wdata;
  logic [ADDR_W-1:0] w_uart_off, w_timer_off;
  logic              w_hit_uart, w_hit_timer;
  logic              w_pready;
  logic [DATA_W-1:0] w_prdata;

  assign w_pick_m1   = i_m1_req && (!i_m0_req || !r_last_grant);
  assign w_req_write = w_pick_m1 ? i_m1_write : i_m0_write;
  assign w_req_addr  = w_pick_m1 ? i_m1_addr  : i_m0_addr;
  assign w_req_wdata = w_pick_m1 ? i_m1_wdata : i_m0_wdata;

  // Offset compare avoids overflow of base+size near the top of the address space.
  assign w_uart_off  = w_req_addr - UART_BASE;
  assign w_timer_off = w_req_addr - TIMER_BASE;
  assign w_hit_uart  = (w_req_addr >= UART_BASE) && (w_uart_off <= WinLast);
  assign w_hit_timer = (w_req_addr >= TIMER_BASE) && (w_timer_off <= WinLast);

  assign w_pready = r_psel_uart ? i_pready_uart : i_pready_timer;
  assign w_prdata = r_psel_uart ? i_prdata_uart : i_prdata_timer;

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_grant_nxt = r_last_grant;
    w_gnt_nxt        = r_gnt;
    w_pwrite_nxt     = r_pwrite;
    w_paddr_nxt      = r_paddr;
    w_pwdata_nxt     = r_pwdata;
    w_psel_uart_nxt  = r_psel_uart;
    w_psel_timer_nxt = r_psel_timer;
    w_penable_nxt    = r_penable;
    w_rdata_nxt      = r_rdata;
    w_fin            = 1'b0;
    w_fin_err        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_m0_req || i_m1_req) begin
          w_gnt_nxt        = w_pick_m1;
          w_last_grant_nxt = w_pick_m1;
          w_pwrite_nxt     = w_req_write;
          w_pwdata_nxt     = w_req_wdata;
          if (w_hit_uart || w_hit_timer) begin
            w_paddr_nxt      = w_hit_uart ? w_uart_off[8:0] : w_timer_off[8:0];
            w_psel_uart_nxt  = w_hit_uart;
            w_psel_timer_nxt = !w_hit_uart;
            w_state_nxt      = StSetup;
          end else begin
            // Unmapped: finish straight away with an error, bus untouched.
            w_fin       = 1'b1;
            w_fin_err   = 1'b1;
            w_state_nxt = StDone;
          end
        end
      end
      StSetup: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = StAccess;
      end
      StAccess: begin
        if (w_pready || (r_cnt == CntLast)) begin
          w_fin     = 1'b1;
          w_fin_err = !w_pready;
          if (w_pready && !r_pwrite) begin
            w_rdata_nxt = w_prdata;
          end
          w_psel_uart_nxt  = 1'b0;
          w_psel_timer_nxt = 1'b0;
          w_penable_nxt    = 1'b0;
          w_cnt_nxt        = '0;
          w_state_nxt      = StDone;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      StDone: begin
        w_cnt_nxt   = '0;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and registered outputs; reset aborts any transfer asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_psel_uart  <= 1'b0;
      r_psel_timer <= 1'b0;
      r_penable    <= 1'b0;
      r_rdata      <= '0;
      r_m0_done    <= 1'b0;
      r_m0_err     <= 1'b0;
      r_m1_done    <= 1'b0;
      r_m1_err     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_gnt        <= w_gnt_nxt;
      r_pwrite     <= w_pwrite_nxt;
      r_paddr      <= w_paddr_nxt;
      r_pwdata     <= w_pwdata_nxt;
      r_psel_uart  <= w_psel_uart_nxt;
      r_psel_timer <= w_psel_timer_nxt;
      r_penable    <= w_penable_nxt;
      r_rdata      <= w_rdata_nxt;
      r_m0_done    <= w_fin && !w_gnt_nxt;
      r_m0_err     <= w_fin && w_fin_err && !w_gnt_nxt;
      r_m1_done    <= w_fin && w_gnt_nxt;
      r_m1_err     <= w_fin && w_fin_err && w_gnt_nxt;
      r_busy       <= (w_state_nxt != StIdle);
    end
  end

  assign o_m0_done    = r_m0_done;
  assign o_m0_err     = r_m0_err;
  assign o_m1_done    = r_m1_done;
  assign o_m1_err     = r_m1_err;
  assign o_rdata      = r_rdata;
  assign o_busy       = r_busy;
  assign o_paddr      = r_paddr;
  assign o_pwrite     = r_pwrite;
  assign o_pwdata     = r_pwdata;
  assign o_psel_uart  = r_psel_uart;
  assign o_psel_timer = r_psel_timer;
  assign o_penable    = r_penable;

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Scoreboard bench for apb_bridge_arbiter: drivers push predicted responses per requester,
// a monitor pops and compares on every done pulse and checks bus behaviour each cycle.
module tb_apb_bridge_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [11:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] rdata, pwdata, prdata_uart, prdata_timer;
  logic        busy, pwrite, psel_uart, psel_timer, penable;
  logic [8:0]  paddr;
  logic        pready_uart, pready_timer;

  // Slave model configuration: override forces wait states / read data.
  logic        ovr_en = 1'b0;
  int          ovr_wait = 0;
  logic [31:0] ovr_data = '0;
  int          acc_cnt;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        uart, tmr, mapped, err, rd_ok, wr;
    logic [8:0]  off;
    logic [31:0] data, wdata;
    int          acc, lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   glog[$];

  always #5 clk = ~clk;

  apb_bridge_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_m0_req      (m0_req),
    .i_m0_write    (m0_write),
    .i_m0_addr     (m0_addr),
    .i_m0_wdata    (m0_wdata),
    .i_m1_req      (m1_req),
    .i_m1_write    (m1_write),
    .i_m1_addr     (m1_addr),
    .i_m1_wdata    (m1_wdata),
    .o_m0_done     (m0_done),
    .o_m0_err      (m0_err),
    .o_m1_done     (m1_done),
    .o_m1_err      (m1_err),
    .o_rdata       (rdata),
    .o_busy        (busy),
    .o_paddr       (paddr),
    .o_pwrite      (pwrite),
    .o_pwdata      (pwdata),
    .o_psel_uart   (psel_uart),
    .o_psel_timer  (psel_timer),
    .o_penable     (penable),
    .i_prdata_uart (prdata_uart),
    .i_prdata_timer(prdata_timer),
    .i_pready_uart (pready_uart),
    .i_pready_timer(pready_timer)
  );

  function automatic int wait_of(logic [8:0] off, logic oen, int ow);
    if (oen) return ow;
    return (off[2:0] == 3'd7) ? 20 : int'(off[1:0]);
  endfunction

  function automatic logic [31:0] data_of(logic uart, logic [8:0] off, logic oen,
                                          logic [31:0] od);
    if (oen) return od;
    return (uart ? 32'h5A00_0000 : 32'hA500_0000) ^ ({23'd0, off} * 32'h0001_0103);
  endfunction

  // Slaves: ready after the configured number of wait states; unselected ready sits high.
  always @(posedge clk or negedge rst) begin
    if (!rst) acc_cnt <= 0;
    else if ((psel_uart || psel_timer) && penable) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    pready_uart  = 1'b1;
    pready_timer = 1'b1;
    if (psel_uart)  pready_uart  = penable && (acc_cnt >= wait_of(paddr, ovr_en, ovr_wait));
    if (psel_timer) pready_timer = penable && (acc_cnt >= wait_of(paddr, ovr_en, ovr_wait));
    prdata_uart  = data_of(1'b1, paddr, ovr_en, ovr_data);
    prdata_timer = data_of(1'b0, paddr, ovr_en, ovr_data);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: window decode, wait-state/timeout outcome and cycle count.
  function automatic exp_t predict(logic [11:0] a, logic w, logic [31:0] d);
    exp_t        e;
    logic [11:0] t;
    int          wt;
    e.uart   = (a >= 12'h800) && (a <= 12'h9FF);
    e.tmr    = (a >= 12'hA00) && (a <= 12'hBFF);
    e.mapped = e.uart || e.tmr;
    t        = e.uart ? a - 12'h800 : a - 12'hA00;
    e.off    = t[8:0];
    wt       = wait_of(e.off, ovr_en, ovr_wait);
    e.acc    = (wt < 16) ? wt + 1 : 16;
    e.err    = !e.mapped || (wt >= 16);
    e.rd_ok  = e.mapped && !w && (wt < 16);
    e.data   = data_of(e.uart, e.off, ovr_en, ovr_data);
    e.wr     = w;
    e.wdata  = d;
    e.lat    = e.mapped ? 2 + e.acc : 1;
    return e;
  endfunction

  // One transfer from requester m; optionally checks cycles from req to done.
  task automatic issue(input int m, input logic [11:0] a, input logic w, input logic [31:0] d,
                       input bit chk_lat);
    exp_t e;
    int   n;
    bit   seen;
    e = predict(a, w, d);
    n = 0;
    seen = 1'b0;
    if (m == 0) begin
      q0.push_back(e);
      m0_write = w; m0_addr = a; m0_wdata = d; m0_req = 1'b1;
    end else begin
      q1.push_back(e);
      m1_write = w; m1_addr = a; m1_wdata = d; m1_req = 1'b1;
    end
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      seen = (m == 0) ? m0_done : m1_done;
    end
    check("done_within_bound", seen, 1'b1);
    if (chk_lat) check("latency", n, e.lat);
    if (m == 0) m0_req = 1'b0;
    else m1_req = 1'b0;
  endtask

  task automatic rand_master(input int m, input int n);
    logic [11:0] bl[6];
    logic [11:0] a;
    int          r;
    bl = '{12'h7FF, 12'h800, 12'h9FF, 12'hA00, 12'hBFF, 12'hC00};
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       a = 12'h800 + 12'($urandom_range(0, 511));
      else if (r < 8)  a = 12'hA00 + 12'($urandom_range(0, 511));
      else if (r == 8) a = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 12'h7FF))
                                                      : 12'h C00 + 12'($urandom_range(0, 1023));
      else             a = bl[$urandom_range(0, 5)];
      issue(m, a, 1'($urandom_range(0, 1)), $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Monitor: per-cycle bus rules, and scoreboard comparison on each done pulse.
  initial begin : monitor
    logic [1:0]  sel_or;
    int          setups, accs, m;
    logic [8:0]  s_paddr;
    logic        s_pwrite, p0, p1, have;
    logic [31:0] s_pwdata, mdl_rdata;
    exp_t        e;
    sel_or = '0; setups = 0; accs = 0; p0 = 0; p1 = 0; mdl_rdata = '0;
    s_paddr = '0; s_pwrite = 0; s_pwdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sel_or = '0; setups = 0; accs = 0; p0 = 0; p1 = 0; mdl_rdata = '0;
        continue;
      end
      check("psel_onehot", psel_uart & psel_timer, 1'b0);
      check("penable_wo_psel", penable & ~(psel_uart | psel_timer), 1'b0);
      check("busy_when_active", (psel_uart | psel_timer | m0_done | m1_done) & ~busy, 1'b0);
      check("done_both", m0_done & m1_done, 1'b0);
      check("done_pulse_m0", m0_done & p0, 1'b0);
      check("done_pulse_m1", m1_done & p1, 1'b0);
      check("err_wo_done", (m0_err & ~m0_done) | (m1_err & ~m1_done), 1'b0);
      sel_or |= {psel_timer, psel_uart};
      if ((psel_uart || psel_timer) && !penable) setups++;
      if ((psel_uart || psel_timer) && penable) begin
        accs++;
        s_paddr = paddr; s_pwrite = pwrite; s_pwdata = pwdata;
      end
      if (m0_done || m1_done) begin
        m = m1_done ? 1 : 0;
        glog.push_back(m);
        have = (m == 0) ? (q0.size() > 0) : (q1.size() > 0);
        check("done_expected", have, 1'b1);
        if (have) begin
          if (m == 0) e = q0.pop_front();
          else e = q1.pop_front();
          check("err", (m == 0) ? m0_err : m1_err, e.err);
          if (e.rd_ok) mdl_rdata = e.data;
          check("rdata", rdata, mdl_rdata);
          check("sel_mask", sel_or, e.uart ? 2'b01 : (e.tmr ? 2'b10 : 2'b00));
          if (e.mapped) begin
            check("setup_cycles", setups, 1);
            check("access_cycles", accs, e.acc);
            check("paddr", s_paddr, e.off);
            check("pwrite", s_pwrite, e.wr);
            if (e.wr) check("pwdata", s_pwdata, e.wdata);
          end else begin
            check("no_bus_cycles", setups + accs, 0);
          end
        end
        sel_or = '0; setups = 0; accs = 0;
      end
      p0 = m0_done;
      p1 = m1_done;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b0;
    m0_req = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {m0_done, m0_err, m1_done, m1_err, rdata, busy, paddr, pwrite,
                            psel_uart, psel_timer, penable}, '0);
    check("reset_pwdata", pwdata, '0);
    #2 rst = 1'b1;
    @(negedge clk);

    // Zero-wait UART write from m0, cycle by cycle.
    ovr_en = 1'b1; ovr_wait = 0;
    q0.push_back(predict(12'h804, 1'b1, 32'hDEAD_BEEF));
    m0_write = 1'b1; m0_addr = 12'h804; m0_wdata = 32'hDEAD_BEEF; m0_req = 1'b1;
    @(negedge clk);
    check("t1_setup_psel", {psel_uart, psel_timer, penable}, 3'b100);
    @(negedge clk);
    check("t1_access", {psel_uart, penable, pwrite}, 3'b111);
    check("t1_paddr", paddr, 9'h004);
    check("t1_pwdata", pwdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t1_done", {m0_done, m0_err, m1_done}, 3'b100);
    m0_req = 1'b0;
    @(negedge clk);

    // Timer read from m1 with 3 wait states.
    ovr_wait = 3; ovr_data = 32'h1234_5678;
    issue(1, 12'hA10, 1'b0, '0, 1'b1);
    check("t2_rdata", rdata, 32'h1234_5678);
    @(negedge clk);

    // Unmapped read from m0: immediate error, rdata kept.
    issue(0, 12'h100, 1'b0, '0, 1'b1);
    check("t4_rdata_kept", rdata, 32'h1234_5678);
    @(negedge clk);

    // Timeout on a stuck UART.
    ovr_wait = 100;
    issue(1, 12'h900, 1'b1, 32'hCAFE_F00D, 1'b1);
    @(negedge clk);
    check("t5_idle_after", {busy, psel_uart, penable}, 3'b000);

    // Continuous contention: grants alternate starting with m0.
    ovr_wait = 0; ovr_data = 32'h0BAD_F00D;
    glog.delete();
    fork
      begin repeat (3) issue(0, 12'h800, 1'($urandom_range(0, 1)), $urandom, 1'b0); end
      begin repeat (3) issue(1, 12'h800, 1'($urandom_range(0, 1)), $urandom, 1'b0); end
    join
    check("t3_grant_count", glog.size(), 6);
    for (int i = 0; i < glog.size(); i++) check("t3_grant_order", glog[i], i % 2);
    @(negedge clk);

    // Reset in ACCESS: async clear, no done for the aborted transfer, m0 first afterwards.
    ovr_wait = 100;
    m0_write = 1'b0; m0_addr = 12'h804; m0_req = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_in_access", {psel_uart, penable}, 2'b11);
    #2 rst = 1'b0;
    #1 check("t6_async_clear", {psel_uart, psel_timer, penable, busy, m0_done, m1_done}, '0);
    m1_write = 1'b1; m1_addr = 12'hA08; m1_req = 1'b1;
    repeat (2) @(negedge clk);
    ovr_wait = 0;
    #2 rst = 1'b1;
    @(negedge clk);
    glog.delete();
    fork
      issue(0, 12'h804, 1'b0, '0, 1'b0);
      issue(1, 12'hA08, 1'b1, 32'h5555_AAAA, 1'b0);
    join
    check("t6_first_grant_m0", (glog.size() > 0) ? glog[0] : -1, 0);
    @(negedge clk);

    // Randomised traffic from both requesters.
    ovr_en = 1'b0;
    fork
      rand_master(0, 25);
      rand_master(1, 25);
    join
    repeat (3) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
